// File: rtl/relcache_pkg.sv
// Shared constants and FSM encoding for the transaction-ID scheduler.
// Optional feature: TRID_TIMEOUT_EN enables per-slot loss detection in trid_scheduler.
package relcache_pkg;

   localparam int NUM_TRID_DEF    = 16;
   localparam int TRID_W_DEF      = 4;
   localparam int TIMEOUT_CYC_DEF = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/trid_scheduler_rr_pick.sv
// Round-robin free-slot picker: first free slot at or above ptr, wrapping to 0.
module rr_pick #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] free,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic         valid
);

   always_comb begin : pick
      logic [W-1:0] idx;
      idx   = '0;
      grant = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = W'((int'(ptr) + k) % N);
         if (!valid && free[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trid_scheduler.sv
// Row-fetch job scheduler handing out transaction-ID slots round-robin and tracking completions.
// Optional feature: define TRID_TIMEOUT_EN to free slots that stay outstanding TIMEOUT_CYC-1 cycles.
module trid_scheduler
   import relcache_pkg::*;
#(
   parameter int NUM_TRID    = NUM_TRID_DEF,
   parameter int TRID_W      = TRID_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [31:0]         i_row_cnt,
   output logic [NUM_TRID-1:0] o_ready,
   output logic                o_req_en,
   input  logic [NUM_TRID-1:0] i_issue,
   input  logic                i_cpl_valid,
   input  logic [TRID_W-1:0]   i_cpl_id,
   output logic                o_busy,
   output logic                o_done,
   output logic [TRID_W:0]     o_outstanding,
   output logic                o_err,
   output logic [TRID_W-1:0]   o_err_id
);

   localparam int CNT_W = TRID_W + 1;

   sched_state_e        state;
   logic [NUM_TRID-1:0] busy;
   logic [TRID_W-1:0]   ptr;
   logic [31:0]         issued;
   logic [31:0]         rows;
   logic                err;
   logic [TRID_W-1:0]   err_id;

   logic [NUM_TRID-1:0] pick_oh;
   logic                pick_vld;
   logic [NUM_TRID-1:0] hit, bad, cpl_oh, cpl_clr, expire, busy_nxt;
   logic                cpl_spur;
   logic [TRID_W-1:0]   hit_idx, bad_idx, exp_idx, ptr_nxt;
   logic [CNT_W-1:0]    outstanding;

   rr_pick #(.N(NUM_TRID), .W(TRID_W)) u_pick (
      .free  (~busy),
      .ptr   (ptr),
      .grant (pick_oh),
      .valid (pick_vld)
   );

   // Grants are only offered while the job still has rows left to issue.
   assign o_ready  = (state == ST_RUN && pick_vld && issued < rows) ? pick_oh : '0;
   assign o_req_en = |o_ready;

   assign hit      = i_issue & o_ready;
   assign bad      = i_issue & ~o_ready;
   assign cpl_oh   = i_cpl_valid ? (NUM_TRID'(1) << i_cpl_id) : '0;
   assign cpl_clr  = cpl_oh & busy;
   assign cpl_spur = i_cpl_valid && (cpl_clr == '0);
   assign busy_nxt = (busy | hit) & ~cpl_clr & ~expire;
   assign ptr_nxt  = (hit_idx == TRID_W'(NUM_TRID - 1)) ? '0 : hit_idx + 1'b1;

   always_comb begin
      hit_idx     = '0;
      bad_idx     = '0;
      exp_idx     = '0;
      outstanding = '0;
      for (int i = NUM_TRID - 1; i >= 0; i--) begin
         if (hit[i])    hit_idx = TRID_W'(i);
         if (bad[i])    bad_idx = TRID_W'(i);
         if (expire[i]) exp_idx = TRID_W'(i);
      end
      for (int i = 0; i < NUM_TRID; i++)
         outstanding = outstanding + CNT_W'(busy[i]);
   end

`ifdef TRID_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT_CYC) + 1;

   logic [NUM_TRID-1:0][AGE_W-1:0] age;

   // A slot expires on the edge where its age would reach TIMEOUT_CYC-1.
   always_comb begin
      expire = '0;
      for (int i = 0; i < NUM_TRID; i++)
         expire[i] = busy[i] && (AGE_W'(age[i] + 1'b1) == AGE_W'(TIMEOUT_CYC - 1));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         age <= '0;
      end else begin
         for (int i = 0; i < NUM_TRID; i++) begin
            if (hit[i] || expire[i] || !busy[i]) age[i] <= '0;
            else                                 age[i] <= age[i] + 1'b1;
         end
      end
   end
`else
   assign expire = '0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= ST_IDLE;
         busy   <= '0;
         ptr    <= '0;
         issued <= '0;
         rows   <= '0;
         err    <= 1'b0;
         err_id <= '0;
      end else begin
         busy <= busy_nxt;
         if (|hit) begin
            issued <= issued + 32'd1;
            ptr    <= ptr_nxt;
         end
         case (state)
            ST_IDLE: if (i_start) begin
               state  <= ST_RUN;
               issued <= '0;
               rows   <= i_row_cnt;
               err    <= 1'b0;
               err_id <= '0;
            end
            ST_RUN:   if (issued == rows)     state <= ST_DRAIN;
            ST_DRAIN: if (outstanding == '0)  state <= ST_DONE;
            default:                          state <= ST_IDLE;
         endcase
         // Error sources are applied after the start-clear so a same-cycle fault is kept.
         if (|bad) begin
            err    <= 1'b1;
            err_id <= bad_idx;
         end
         if (cpl_spur) begin
            err    <= 1'b1;
            err_id <= i_cpl_id;
         end
         if (|expire) begin
            err    <= 1'b1;
            err_id <= exp_idx;
         end
      end
   end

   assign o_busy        = (state != ST_IDLE);
   assign o_done        = (state == ST_DONE);
   assign o_outstanding = outstanding;
   assign o_err         = err;
   assign o_err_id      = err_id;

endmodule

// File: doc/trid_scheduler.md
TRID_SCHEDULER -- requirements
Module: trid_scheduler

Interface
REQ-001 SHALL have parameter NUM_TRID, default 16, number of transaction-ID slots (TRIDNUM).
REQ-002 SHALL have parameter TRID_W, default 4, slot index width (TRIDBIT).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, cycles before an outstanding slot is declared lost.
REQ-004 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_start  in  1  one-cycle pulse launching a row-fetch job.
REQ-007 SHALL have port i_row_cnt  in  32  rows (read requests) in the job, sampled on accepted i_start.
REQ-008 SHALL have port o_ready  out  NUM_TRID  one-hot grant of the next free slot, driven to requestor i_ready.
REQ-009 SHALL have port o_req_en  out  1  request-generation enable, driven to requestor i_en.
REQ-010 SHALL have port i_issue  in  NUM_TRID  per-slot issue strobes from requestor o_en.
REQ-011 SHALL have port i_cpl_valid  in  1  read completion strobe.
REQ-012 SHALL have port i_cpl_id  in  TRID_W  slot of the completion.
REQ-013 SHALL have ports o_busy (1), o_done (1, pulse), o_outstanding (TRID_W+1), o_err (1, sticky), o_err_id (TRID_W).

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on i_start; RUN->DRAIN when issued count == row count; DRAIN->DONE when outstanding == 0; DONE->IDLE unconditionally.
REQ-015 SHALL ignore i_start outside IDLE.
REQ-016 SHALL keep a busy bit per slot and a round-robin pointer; o_ready = one-hot of the first free slot at or above the pointer (wrapping past NUM_TRID-1 to 0), combinational from registered state.
REQ-017 SHALL drive o_ready = 0 unless state == RUN, a free slot exists, and issued < row count.
REQ-018 SHALL assert o_req_en = 1 exactly when o_ready != 0.
REQ-019 SHALL accept an issue only when i_issue & o_ready is nonzero; it sets that busy bit, increments issued count (32-bit), and moves pointer to granted index+1 mod NUM_TRID, all visible next cycle.
REQ-020 SHALL ignore i_issue bits outside o_ready and set o_err with o_err_id = lowest offending bit.
REQ-021 SHALL, on i_cpl_valid for a busy slot, clear its busy bit next cycle; completion for a free slot is ignored and sets o_err with o_err_id = i_cpl_id.
REQ-022 SHALL apply simultaneous issue and completion in the same cycle, leaving o_outstanding unchanged.
REQ-023 SHALL drive o_outstanding = population count of busy bits (0..NUM_TRID).
REQ-024 SHALL assert o_done for exactly the DONE cycle; o_busy = 1 in RUN, DRAIN, DONE.
REQ-025 SHALL with i_row_cnt = 0 pass RUN->DRAIN->DONE with no grants: start at cycle N, o_done at N+3.
REQ-026 SHALL clear o_err only on reset or on an accepted i_start.

Reset
REQ-027 SHALL on i_rst force state IDLE, busy bits 0, pointer 0, counts 0, o_err 0, o_err_id 0, all outputs 0, including mid-job; completions after reset count as spurious per REQ-021.

Configuration
REQ-028 SHALL with TRID_TIMEOUT_EN defined keep a per-slot age counter, cleared on issue, incremented while busy; at TIMEOUT_CYC-1 the slot is freed, o_err set, o_err_id = slot (lowest index on ties).
REQ-029 SHALL without TRID_TIMEOUT_EN contain no age counters; slots free only on completion.

Structure
REQ-030 SHALL take NUM_TRID, TRID_W, state enum and default TIMEOUT_CYC from shared package relcache_pkg.
REQ-031 SHALL place round-robin free-slot search in sub-module rr_pick (inputs free vector, pointer; output one-hot, valid).

Verification
REQ-032 SHALL cover: i_row_cnt=3, issue each grant next cycle -> grants slots 0,1,2, completions -> o_done once, o_outstanding returns 0.
REQ-033 SHALL cover: i_row_cnt=20, no completions -> 16 grants then o_ready=0; complete slot 5 -> next grant slot 5, remaining grants follow.
REQ-034 SHALL cover: same-cycle issue of slot 3 and completion of slot 1 with outstanding=4 -> o_outstanding stays 4.
REQ-035 SHALL cover: completion id 7 while slot 7 free -> o_err=1, o_err_id=7, no state change.
REQ-036 SHALL cover: i_rst in DRAIN with 5 outstanding -> next cycle all outputs 0, state IDLE.
REQ-037 SHALL cover: TRID_TIMEOUT_EN, TIMEOUT_CYC=8, slot 0 issued, never completed -> freed and o_err_id=0 exactly 7 cycles after issue.
